// File: rtl/morse_key_frontend.sv
// rtl/morse_key_frontend.sv - push-button conditioner and Morse dot/dash/gap event generator
// Optional word-boundary detection is enabled by defining MORSE_KEY_WORD_GAP_EN.
module morse_key_frontend #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DOT_MAX_CYCLES  = 2500,
    parameter int CHAR_GAP_CYCLES = 3000,
    parameter int WORD_GAP_CYCLES = 7000,
    parameter int CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic button,
    output logic key_level,
    output logic sym_valid,
    output logic sym_dash,
    output logic char_end,
    output logic word_end
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESS     = 2'd1,
        GAP       = 2'd2,
        WORD_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOT_MAX   = CNT_W'(DOT_MAX_CYCLES);
    localparam logic [CNT_W-1:0] CHAR_LAST = CNT_W'(CHAR_GAP_CYCLES - 1);
`ifdef MORSE_KEY_WORD_GAP_EN
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(WORD_GAP_CYCLES - 1);
`endif

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             key_q, key_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             sym_valid_q, sym_valid_d;
    logic             sym_dash_q, sym_dash_d;
    logic             char_end_q, char_end_d;
`ifdef MORSE_KEY_WORD_GAP_EN
    logic             word_end_q, word_end_d;
`endif
    logic             key_rise;
    logic             key_fall;

    always_comb begin
        sync1_d  = button;
        sync2_d  = sync1_q;
        key_d    = key_q;
        db_cnt_d = '0;
        if (sync2_q != key_q) begin
            if (db_cnt_q == DB_LAST) begin
                key_d = ~key_q;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
        // FSM reacts to the debounced edge on the same clock that updates key_level
        key_rise = key_d & ~key_q;
        key_fall = ~key_d & key_q;

        state_d     = state_q;
        press_cnt_d = press_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        sym_valid_d = 1'b0;
        sym_dash_d  = sym_dash_q;
        char_end_d  = 1'b0;
`ifdef MORSE_KEY_WORD_GAP_EN
        word_end_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (key_rise) begin
                    state_d     = PRESS;
                    press_cnt_d = CNT_W'(1);
                end
            end
            PRESS: begin
                if (key_fall) begin
                    state_d     = GAP;
                    sym_valid_d = 1'b1;
                    sym_dash_d  = (press_cnt_q > DOT_MAX);
                    gap_cnt_d   = '0;
                end else if (press_cnt_q != '1) begin
                    press_cnt_d = press_cnt_q + 1'b1;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == CHAR_LAST) begin
                    char_end_d = 1'b1;
`ifdef MORSE_KEY_WORD_GAP_EN
                    state_d    = WORD_WAIT;
`else
                    state_d    = IDLE;
`endif
                end
                if (key_rise) begin
                    state_d     = PRESS;
                    press_cnt_d = CNT_W'(1);
                end
            end
`ifdef MORSE_KEY_WORD_GAP_EN
            WORD_WAIT: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_cnt_q == WORD_LAST) begin
                    word_end_d = 1'b1;
                    state_d    = IDLE;
                end
                if (key_rise) begin
                    state_d     = PRESS;
                    press_cnt_d = CNT_W'(1);
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            key_q       <= 1'b0;
            db_cnt_q    <= '0;
            state_q     <= IDLE;
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            sym_valid_q <= 1'b0;
            sym_dash_q  <= 1'b0;
            char_end_q  <= 1'b0;
`ifdef MORSE_KEY_WORD_GAP_EN
            word_end_q  <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            key_q       <= key_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            sym_valid_q <= sym_valid_d;
            sym_dash_q  <= sym_dash_d;
            char_end_q  <= char_end_d;
`ifdef MORSE_KEY_WORD_GAP_EN
            word_end_q  <= word_end_d;
`endif
        end
    end

    assign key_level = key_q;
    assign sym_valid = sym_valid_q;
    assign sym_dash  = sym_dash_q;
    assign char_end  = char_end_q;
`ifdef MORSE_KEY_WORD_GAP_EN
    assign word_end  = word_end_q;
`else
    assign word_end  = 1'b0;
`endif

endmodule

// File: tb/tb_morse_key_frontend.sv
// tb/tb_morse_key_frontend.sv - randomized self-checking bench for morse_key_frontend
module tb_morse_key_frontend;

    localparam int DEB  = 16;
    localparam int DOT  = 2500;
    localparam int CHAR = 3000;
    localparam int WORD = 7000;
    localparam int LAT  = DEB + 2;

    logic clk = 1'b0;
    logic rst;
    logic button;
    logic key_level, sym_valid, sym_dash, char_end, word_end;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int press_start = 0;
    int last_f = 0;
    bit pend = 1'b0;
    bit m_key = 1'b0;

    // Expected events keyed by the cycle number in which they must be visible
    bit ev_kr[int];
    bit ev_kf[int];
    bit ev_rst[int];
    bit ev_sv[int];
    bit ev_dash[int];
    bit ev_ce[int];
    bit ev_we[int];

    morse_key_frontend #(
        .DEBOUNCE_CYCLES(DEB),
        .DOT_MAX_CYCLES (DOT),
        .CHAR_GAP_CYCLES(CHAR),
        .WORD_GAP_CYCLES(WORD),
        .CNT_W          (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .button   (button),
        .key_level(key_level),
        .sym_valid(sym_valid),
        .sym_dash (sym_dash),
        .char_end (char_end),
        .word_end (word_end)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin : chk
        bit k;
        k = m_key;
        if (ev_kr.exists(cyc)) k = 1'b1;
        if (ev_kf.exists(cyc)) k = 1'b0;
        if (ev_rst.exists(cyc)) begin
            k = 1'b0;
            check("rst_sym_dash", 32'(sym_dash), 32'd0);
        end
        m_key <= k;
        check("key_level", 32'(key_level), 32'(k));
        check("sym_valid", 32'(sym_valid), 32'(ev_sv.exists(cyc)));
        if (ev_sv.exists(cyc)) check("sym_dash", 32'(sym_dash), 32'(ev_dash[cyc]));
        check("char_end", 32'(char_end), 32'(ev_ce.exists(cyc)));
        check("word_end", 32'(word_end), 32'(ev_we.exists(cyc)));
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold the current level for len cycles, optionally with one sub-debounce glitch inside
    task automatic hold(input int len, input bit gl);
        int a, g;
        if (gl && len >= 60) begin
            a = 20 + $urandom_range(0, len - 60);
            g = $urandom_range(1, DEB - 1);
            step(a);
            button = ~button;
            step(g);
            button = ~button;
            step(len - a - g);
        end else begin
            step(len);
        end
    endtask

    task automatic key_press(input int len, input bit gl);
        int r;
        r = cyc + LAT;
        ev_kr[r] = 1'b1;
        if (pend) begin
            if (r < last_f + CHAR && ev_ce.exists(last_f + CHAR)) ev_ce.delete(last_f + CHAR);
            if (r < last_f + WORD && ev_we.exists(last_f + WORD)) ev_we.delete(last_f + WORD);
        end
        pend = 1'b0;
        press_start = cyc;
        button = 1'b1;
        hold(len, gl);
    endtask

    task automatic key_release(input int len, input bit gl);
        int f;
        f = cyc + LAT;
        ev_kf[f] = 1'b1;
        ev_sv[f] = 1'b1;
        ev_dash[f] = ((cyc - press_start) > DOT);
        ev_ce[f + CHAR] = 1'b1;
`ifdef MORSE_KEY_WORD_GAP_EN
        ev_we[f + WORD] = 1'b1;
`endif
        last_f = f;
        pend = 1'b1;
        button = 1'b0;
        hold(len, gl);
    endtask

    task automatic apply_reset(input int n);
        int k;
        k = cyc;
        rst = 1'b1;
        for (int c = k + 1; c <= k + WORD + CHAR + 100; c++) begin
            if (ev_kr.exists(c))   ev_kr.delete(c);
            if (ev_kf.exists(c))   ev_kf.delete(c);
            if (ev_sv.exists(c))   ev_sv.delete(c);
            if (ev_dash.exists(c)) ev_dash.delete(c);
            if (ev_ce.exists(c))   ev_ce.delete(c);
            if (ev_we.exists(c))   ev_we.delete(c);
        end
        for (int c = k + 1; c <= k + n; c++) ev_rst[c] = 1'b1;
        pend = 1'b0;
        step(n);
        rst = 1'b0;
        if (button) begin
            ev_kr[cyc + LAT] = 1'b1;
            press_start = cyc;
        end
    endtask

    initial begin
        int pl, rl;
        bit g1, g2;
        button = 1'b0;
        rst    = 1'b1;
        apply_reset(10);

        // Short button pulse never reaches key_level
        button = 1'b1;
        step(10);
        button = 1'b0;
        step(50);

        // U: ..-
        key_press(1512, 1'b0);
        key_release(1512, 1'b0);
        key_press(1512, 1'b0);
        key_release(1512, 1'b0);
        key_press(3750, 1'b0);
        key_release(10000, 1'b0);

        // Dot/dash boundary and char-gap boundary
        key_press(2500, 1'b0);
        key_release(3000, 1'b0);
        key_press(2501, 1'b0);
        key_release(2999, 1'b0);
        key_press(100, 1'b0);
        key_release(5000, 1'b0);
        key_press(200, 1'b0);
        key_release(3500, 1'b0);

        // Reset 100 cycles into a press with the button still held
        key_press(118, 1'b0);
        apply_reset(10);
        step(3650);
        key_release(3000, 1'b0);

        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 2))
                0:       pl = $urandom_range(40, 2400);
                1:       pl = $urandom_range(2495, 2505);
                default: pl = $urandom_range(2600, 4000);
            endcase
            case ($urandom_range(0, 3))
                0:       rl = $urandom_range(40, 2900);
                1:       rl = $urandom_range(2995, 3005);
                2:       rl = $urandom_range(3100, 6900);
                default: rl = $urandom_range(6995, 7005);
            endcase
            g1 = 1'($urandom_range(0, 1));
            g2 = 1'($urandom_range(0, 1));
            key_press(pl, g1);
            key_release((i == 3) ? WORD + 100 : rl, g2);
        end

        step(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
